os_result_drain: RTL and testbench

OS_RESULT_DRAIN -- requirements
Module: os_result_drain

---
 rtl/os_result_drain.sv | 107 ++++++++++
 tb/tb_os_result_drain.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_result_drain.sv
// Drains an ARRAY_SIZE x ARRAY_SIZE output-stationary result array: shifts the
// shadow chains into a local buffer, then streams it row-major over a valid/ready port.
module os_result_drain #(
  parameter int ARRAY_SIZE = 4,
  parameter int ACC_WIDTH  = 24,
  parameter int OUT_WIDTH  = 32,
  localparam int IDX_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        drain_start,
  input  logic signed [ACC_WIDTH-1:0] head_result [ARRAY_SIZE],
  output logic                        shift_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic [IDX_W-1:0]            out_row,
  output logic [IDX_W-1:0]            out_col,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT, DONE} state_t;

  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(ARRAY_SIZE - 1);

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            row_q, col_q;
  logic signed [ACC_WIDTH-1:0] buffer [ARRAY_SIZE][ARRAY_SIZE];
  logic signed [ACC_WIDTH-1:0] cur;
  logic signed [OUT_WIDTH-1:0] cur_ext;
  logic                        last_col, last_row, xfer;

  assign last_col = (col_q == MAX_IDX);
  assign last_row = (row_q == MAX_IDX);
  assign xfer     = (state_q == EMIT) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    shift_en  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (drain_start) state_d = CAPTURE;
      end
      CAPTURE: begin
        shift_en = 1'b1;
        if (last_col) state_d = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && last_row && last_col) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // col_q doubles as the capture column index k while in CAPTURE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      case (state_q)
        CAPTURE: col_q <= last_col ? '0 : col_q + 1'b1;
        EMIT: begin
          if (xfer) begin
            col_q <= last_col ? '0 : col_q + 1'b1;
            if (last_col) row_q <= last_row ? '0 : row_q + 1'b1;
          end
        end
        default: begin
          row_q <= '0;
          col_q <= '0;
        end
      endcase
    end
  end

  // Buffer is never presented outside EMIT, so it needs no reset
  always_ff @(posedge clk) begin
    if (state_q == CAPTURE) begin
      for (int i = 0; i < ARRAY_SIZE; i++) buffer[i][col_q] <= head_result[i];
    end
  end

  assign cur      = buffer[row_q][col_q];
  assign cur_ext  = OUT_WIDTH'(cur);
  assign out_data = (state_q == EMIT) ? cur_ext : '0;
  assign out_row  = (state_q == EMIT) ? row_q : '0;
  assign out_col  = (state_q == EMIT) ? col_q : '0;
  assign out_last = (state_q == EMIT) && last_row && last_col;

endmodule

// File: tb/tb_os_result_drain.sv
// Self-checking bench for os_result_drain: a shadow-array model feeds the DUT and
// each drain is checked against the loaded matrix read out row-major.
module tb_os_result_drain;

  localparam int N  = 4;
  localparam int AW = 24;
  localparam int OW = 32;

  logic                 clk = 1'b0;
  logic                 rst_n, drain_start, out_ready;
  logic signed [AW-1:0] head_result [N];
  logic                 shift_en, out_valid, out_last, busy, done;
  logic [OW-1:0]        out_data;
  logic [1:0]           out_row, out_col;

  logic [AW-1:0] shadow   [N][N];
  logic [AW-1:0] load_mat [N][N];
  logic          load = 1'b0;

  int tests_run = 0;
  int failures  = 0;

  int r_shifts, r_emit_shift, r_ndone, r_done_cyc, r_first_valid;
  int r_first_shift, r_last_shift, r_unstable, r_post_busy, r_timeout;
  int            n_got;
  logic [OW-1:0] got_data [64];
  int            got_row  [64];
  int            got_col  [64];
  logic          got_last [64];

  os_result_drain #(.ARRAY_SIZE(N), .ACC_WIDTH(AW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst_n(rst_n), .drain_start(drain_start), .head_result(head_result),
    .shift_en(shift_en), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Shadow chain model: each shift moves every row one column toward column 0
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) shadow[i][j] <= load_mat[i][j];
    end else if (shift_en) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N-1; j++) shadow[i][j] <= shadow[i][j+1];
        shadow[i][N-1] <= 24'h5A5A5A;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) head_result[i] = shadow[i][0];
  end

  function automatic logic [OW-1:0] exp_word(input int w);
    logic [AW-1:0] m;
    m = load_mat[w / N][w % N];
    return {{(OW-AW){m[AW-1]}}, m};
  endfunction

  task automatic load_random();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) load_mat[i][j] = AW'($urandom);
  endtask

  task automatic push_load();
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
  endtask

  // Pulses drain_start from IDLE and records what the DUT does, cycle by cycle.
  task automatic run_drain(input int rmode, input int s1, input int s2, input int s3);
    logic [OW-1:0] pd;
    int            prow, pcol;
    logic          plast, stalled;
    r_shifts = 0; r_emit_shift = 0; r_ndone = 0; r_done_cyc = -1; r_first_valid = -1;
    r_first_shift = -1; r_last_shift = -1; r_unstable = 0; r_post_busy = 0; n_got = 0;
    stalled = 1'b0; pd = '0; prow = 0; pcol = 0; plast = 1'b0;
    drain_start = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      drain_start = (c == s1) || (c == s2) || (c == s3);
      out_ready   = (rmode == 0) ? 1'b1 : 1'($urandom % 2);
      if (shift_en) begin
        r_shifts++;
        if (r_first_shift < 0) r_first_shift = c;
        r_last_shift = c;
        if (out_valid) r_emit_shift++;
      end
      if (out_valid) begin
        if (r_first_valid < 0) r_first_valid = c;
        if (stalled && (out_data !== pd || int'(out_row) != prow ||
                        int'(out_col) != pcol || out_last !== plast)) r_unstable++;
        if (out_ready && n_got < 64) begin
          got_data[n_got] = out_data;
          got_row[n_got]  = int'(out_row);
          got_col[n_got]  = int'(out_col);
          got_last[n_got] = out_last;
          n_got++;
        end
        stalled = !out_ready;
        pd = out_data; prow = int'(out_row); pcol = int'(out_col); plast = out_last;
      end else begin
        if (stalled) r_unstable++;
        stalled = 1'b0;
      end
      if (done) begin
        r_ndone++;
        if (r_done_cyc < 0) r_done_cyc = c;
      end
      if (r_done_cyc > 0 && c > r_done_cyc && busy) r_post_busy++;
      if (r_done_cyc > 0 && c >= r_done_cyc + 4) break;
    end
    r_timeout   = (r_done_cyc < 0) ? 1 : 0;
    drain_start = 1'b0;
    out_ready   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drain_start = 1'b0; out_ready = 1'b0;
    #12;
    tests_run++;
    if ({shift_en, out_valid, busy, done, out_last} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got %b want 00000", {shift_en, out_valid, busy, done, out_last});
    end
    tests_run++;
    if (out_data !== '0 || out_row !== 2'd0 || out_col !== 2'd0) begin
      failures++;
      $display("FAIL reset_data got %h/%0d/%0d want 0/0/0", out_data, out_row, out_col);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || shift_en !== 1'b0) begin
        failures++;
        $display("FAIL idle_after_reset got busy=%b shift=%b want 0 0", busy, shift_en);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) load_mat[i][j] = AW'(16*i + j);
    push_load();
    run_drain(0, 0, 0, 0);
    tests_run++;
    if (r_timeout != 0) begin failures++; $display("FAIL basic_timeout got %0d want 0", r_timeout); end
    tests_run++;
    if (r_first_shift != 1 || r_last_shift != N || r_shifts != N) begin
      failures++;
      $display("FAIL basic_shift got first=%0d last=%0d n=%0d want 1 4 4", r_first_shift, r_last_shift, r_shifts);
    end
    tests_run++;
    if (r_first_valid != N + 1) begin
      failures++; $display("FAIL basic_first_valid got %0d want %0d", r_first_valid, N + 1);
    end
    tests_run++;
    if (n_got != N*N) begin failures++; $display("FAIL basic_words got %0d want %0d", n_got, N*N); end
    tests_run++;
    if (r_done_cyc != N + N*N + 1 || r_ndone != 1) begin
      failures++; $display("FAIL basic_done got cyc=%0d n=%0d want 21 1", r_done_cyc, r_ndone);
    end
    for (int w = 0; w < n_got && w < N*N; w++) begin
      tests_run++;
      if (got_data[w] !== OW'(16*(w / N) + (w % N)) || got_row[w] != w / N ||
          got_col[w] != w % N || got_last[w] !== (w == N*N-1)) begin
        failures++;
        $display("FAIL basic_word%0d got %h r%0d c%0d l%b want %h r%0d c%0d", w, got_data[w],
                 got_row[w], got_col[w], got_last[w], 16*(w / N) + (w % N), w / N, w % N);
      end
    end
  endtask

  task automatic test_sign_ext();
    load_random();
    load_mat[0][0] = 24'hFFFFF6;
    load_mat[1][3] = 24'h7FFFFF;
    push_load();
    run_drain(0, 0, 0, 0);
    tests_run++;
    if (n_got != N*N) begin failures++; $display("FAIL sext_words got %0d want %0d", n_got, N*N); end
    tests_run++;
    if (got_data[0] !== 32'hFFFFFFF6) begin
      failures++; $display("FAIL sext_neg got %h want FFFFFFF6", got_data[0]);
    end
    tests_run++;
    if (got_data[7] !== 32'h007FFFFF) begin
      failures++; $display("FAIL sext_pos got %h want 007FFFFF", got_data[7]);
    end
    for (int w = 0; w < n_got && w < N*N; w++) begin
      tests_run++;
      if (got_data[w] !== exp_word(w)) begin
        failures++; $display("FAIL sext_word%0d got %h want %h", w, got_data[w], exp_word(w));
      end
    end
  endtask

  task automatic test_backpressure();
    for (int it = 0; it < 3; it++) begin
      load_random();
      push_load();
      run_drain(1, 0, 0, 0);
      tests_run++;
      if (r_timeout != 0 || n_got != N*N || r_ndone != 1) begin
        failures++;
        $display("FAIL bp_count%0d got to=%0d words=%0d done=%0d want 0 16 1", it, r_timeout, n_got, r_ndone);
      end
      tests_run++;
      if (r_unstable != 0) begin failures++; $display("FAIL bp_stable%0d got %0d want 0", it, r_unstable); end
      tests_run++;
      if (r_emit_shift != 0 || r_shifts != N) begin
        failures++;
        $display("FAIL bp_shift%0d got emit=%0d total=%0d want 0 4", it, r_emit_shift, r_shifts);
      end
      for (int w = 0; w < n_got && w < N*N; w++) begin
        tests_run++;
        if (got_data[w] !== exp_word(w) || got_row[w] != w / N || got_col[w] != w % N ||
            got_last[w] !== (w == N*N-1)) begin
          failures++;
          $display("FAIL bp_word%0d.%0d got %h r%0d c%0d l%b want %h", it, w, got_data[w],
                   got_row[w], got_col[w], got_last[w], exp_word(w));
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    load_random();
    push_load();
    run_drain(0, 2, 8, N + N*N + 1);
    tests_run++;
    if (r_shifts != N || n_got != N*N || r_ndone != 1) begin
      failures++;
      $display("FAIL ign_counts got sh=%0d words=%0d done=%0d want 4 16 1", r_shifts, n_got, r_ndone);
    end
    tests_run++;
    if (r_done_cyc != N + N*N + 1 || r_post_busy != 0) begin
      failures++;
      $display("FAIL ign_done got cyc=%0d post_busy=%0d want 21 0", r_done_cyc, r_post_busy);
    end
    for (int w = 0; w < n_got && w < N*N; w++) begin
      tests_run++;
      if (got_data[w] !== exp_word(w)) begin
        failures++; $display("FAIL ign_word%0d got %h want %h", w, got_data[w], exp_word(w));
      end
    end
    load_random();
    push_load();
    run_drain(0, 0, 0, 0);
    tests_run++;
    if (r_first_shift != 1 || r_shifts != N || n_got != N*N) begin
      failures++;
      $display("FAIL ign_next got first=%0d sh=%0d words=%0d want 1 4 16", r_first_shift, r_shifts, n_got);
    end
  endtask

  task automatic check_fresh_drain(input string tag);
    load_random();
    push_load();
    run_drain(0, 0, 0, 0);
    tests_run++;
    if (r_shifts != N || r_first_valid != N + 1 || n_got != N*N || r_done_cyc != N + N*N + 1) begin
      failures++;
      $display("FAIL %s_fresh got sh=%0d fv=%0d words=%0d done=%0d want 4 5 16 21", tag,
               r_shifts, r_first_valid, n_got, r_done_cyc);
    end
    for (int w = 0; w < n_got && w < N*N; w++) begin
      tests_run++;
      if (got_data[w] !== exp_word(w)) begin
        failures++; $display("FAIL %s_word%0d got %h want %h", tag, w, got_data[w], exp_word(w));
      end
    end
  endtask

  task automatic test_reset_mid();
    // Mid-CAPTURE: two shifts done, third in progress
    load_random();
    push_load();
    drain_start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drain_start = 1'b0;
    end
    tests_run++;
    if (shift_en !== 1'b1) begin failures++; $display("FAIL rcap_pre got shift=%b want 1", shift_en); end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (shift_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rcap_drop got shift=%b busy=%b valid=%b want 0 0 0", shift_en, busy, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_fresh_drain("rcap");

    // Mid-EMIT: five words transferred, word 5 (row 1, col 1) on the port
    load_random();
    push_load();
    drain_start = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= N + 6; c++) begin
      @(negedge clk);
      drain_start = 1'b0;
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_row !== 2'd1 || out_col !== 2'd1 || out_data !== exp_word(5)) begin
      failures++;
      $display("FAIL remit_pre got v=%b r%0d c%0d %h want 1 r1 c1 %h", out_valid, out_row, out_col,
               out_data, exp_word(5));
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || shift_en !== 1'b0) begin
      failures++;
      $display("FAIL remit_drop got v=%b l=%b busy=%b sh=%b want 0 0 0 0", out_valid, out_last, busy, shift_en);
    end
    tests_run++;
    if (out_data !== '0 || out_row !== 2'd0 || out_col !== 2'd0) begin
      failures++;
      $display("FAIL remit_data got %h r%0d c%0d want 0 r0 c0", out_data, out_row, out_col);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_fresh_drain("remit");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_ext();
    test_backpressure();
    test_ignored_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
